// File: rtl/logic_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_seq
// Brief    : Registered bitwise ops (1 cycle) and iterative CLZ/CTZ/CPOP
//            (CNT_STEP bits per cycle) behind valid/ready handshakes.
//            Optional macro LOGIC_W32_EN adds a 32-bit `word` mode.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_seq #(
  parameter int XLEN     = 64,
  parameter int CNT_STEP = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [3:0]      op,
`ifdef LOGIC_W32_EN
  input  logic            word,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW     = $clog2(XLEN + 1);
  localparam int SW     = $clog2(CNT_STEP + 1);
  localparam int NCHUNK = XLEN / CNT_STEP;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [3:0] c_OP_AND  = 4'd0;
  localparam logic [3:0] c_OP_XOR  = 4'd1;
  localparam logic [3:0] c_OP_OR   = 4'd2;
  localparam logic [3:0] c_OP_ANDN = 4'd3;
  localparam logic [3:0] c_OP_ORN  = 4'd4;
  localparam logic [3:0] c_OP_XNOR = 4'd5;
  localparam logic [3:0] c_OP_CLZ  = 4'd6;
  localparam logic [3:0] c_OP_CTZ  = 4'd7;
  localparam logic [3:0] c_OP_CPOP = 4'd8;

  localparam logic [1:0] c_K_CLZ  = 2'd0;
  localparam logic [1:0] c_K_CTZ  = 2'd1;
  localparam logic [1:0] c_K_CPOP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_src;
  logic [1:0]        r_kind;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_count;
  logic              r_found;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_is_count;
  logic [XLEN-1:0]   w_logic;
  logic [XLEN-1:0]   w_bitwise;
  logic [CNT_STEP-1:0] w_hi_chunk;
  logic [CNT_STEP-1:0] w_lo_chunk;
  logic [SW-1:0]     w_lz;
  logic [SW-1:0]     w_tz;
  logic [SW-1:0]     w_pop;
  logic [SW-1:0]     w_add;
  logic              w_nonzero;
  logic [CW-1:0]     w_count_next;

  assign in_ready  = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_CALC);
  assign result    = r_result;

  assign w_is_count = (op == c_OP_CLZ) || (op == c_OP_CTZ) || (op == c_OP_CPOP);

  always_comb begin
    w_logic = '0;
    case (op)
      c_OP_AND:  w_logic = src1 & src2;
      c_OP_XOR:  w_logic = src1 ^ src2;
      c_OP_OR:   w_logic = src1 | src2;
      c_OP_ANDN: w_logic = src1 & ~src2;
      c_OP_ORN:  w_logic = src1 | ~src2;
      c_OP_XNOR: w_logic = ~(src1 ^ src2);
      default:   w_logic = '0;
    endcase
    w_bitwise = w_logic;
`ifdef LOGIC_W32_EN
    if (word) w_bitwise = {{(XLEN-32){w_logic[31]}}, w_logic[31:0]};
`endif
  end

  // CLZ shifts left and inspects the top chunk; CTZ/CPOP shift right and inspect the bottom.
  always_comb begin
    w_hi_chunk = r_src[XLEN-1 -: CNT_STEP];
    w_lo_chunk = r_src[CNT_STEP-1:0];
    w_lz  = SW'(CNT_STEP);
    w_tz  = SW'(CNT_STEP);
    w_pop = '0;
    for (int i = 0; i < CNT_STEP; i++) begin
      if (w_hi_chunk[i]) w_lz = SW'(CNT_STEP - 1 - i);
    end
    for (int i = CNT_STEP - 1; i >= 0; i--) begin
      if (w_lo_chunk[i]) w_tz = SW'(i);
    end
    for (int i = 0; i < CNT_STEP; i++) begin
      w_pop = w_pop + SW'(w_lo_chunk[i]);
    end
    case (r_kind)
      c_K_CLZ: begin
        w_add     = r_found ? '0 : w_lz;
        w_nonzero = |w_hi_chunk;
      end
      c_K_CTZ: begin
        w_add     = r_found ? '0 : w_tz;
        w_nonzero = |w_lo_chunk;
      end
      default: begin
        w_add     = w_pop;
        w_nonzero = |w_lo_chunk;
      end
    endcase
    w_count_next = r_count + CW'(w_add);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_src    <= '0;
      r_kind   <= c_K_CLZ;
      r_idx    <= '0;
      r_count  <= '0;
      r_found  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_is_count) begin
              r_state <= S_CALC;
              r_src   <= src1;
              r_idx   <= IW'(NCHUNK - 1);
              r_count <= '0;
              r_found <= 1'b0;
              case (op)
                c_OP_CLZ: r_kind <= c_K_CLZ;
                c_OP_CTZ: r_kind <= c_K_CTZ;
                default:  r_kind <= c_K_CPOP;
              endcase
`ifdef LOGIC_W32_EN
              // Word mode: park the low half where the scan starts and run fewer chunks.
              if (word) begin
                r_idx <= IW'(32 / CNT_STEP - 1);
                if (op == c_OP_CLZ) r_src <= {src1[31:0], {(XLEN-32){1'b0}}};
                else                r_src <= {{(XLEN-32){1'b0}}, src1[31:0]};
              end
`endif
            end else begin
              r_state  <= S_DONE;
              r_result <= w_bitwise;
            end
          end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_count <= w_count_next;
          r_found <= r_found | w_nonzero;
          if (r_kind == c_K_CLZ) r_src <= r_src << CNT_STEP;
          else                   r_src <= r_src >> CNT_STEP;
          if (r_idx == '0) begin
            r_state  <= S_DONE;
            r_result <= {{(XLEN-CW){1'b0}}, w_count_next};
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
